// File: rtl/regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Funnels writebacks from N_REQ producers (0 = ALU, 1 = LSU, 2 = CSR) into
// the single register-file write port (A3/WD3/WE3). A round-robin arbiter
// picks one producer per cycle. A per-register pending-write scoreboard is
// set by decode at issue and cleared when the matching writeback is granted.
// Decode reads the scoreboard through rs1_busy/rs2_busy for RAW hazard checks.
// ----------------------------------------------------------------------------
module regfile_wb_scheduler #(
    parameter int DATA_WIDTH        = 32,
    parameter int NB_OF_REGS        = 32,
    parameter int ADDRESS_BIT_WIDTH = 5,
    parameter int N_REQ             = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,

    // writeback requesters, requester k at slice k
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*ADDRESS_BIT_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]          req_data,
    output logic [N_REQ-1:0]                     req_ready,

    // decode side: issue marks a destination pending, rs queries read it
    input  logic                                 issue_valid,
    input  logic [ADDRESS_BIT_WIDTH-1:0]         issue_rd,
    input  logic [ADDRESS_BIT_WIDTH-1:0]         rs1_addr,
    input  logic [ADDRESS_BIT_WIDTH-1:0]         rs2_addr,
    output logic                                 rs1_busy,
    output logic                                 rs2_busy,

    // register-file write port
    output logic                                 WE3,
    output logic [ADDRESS_BIT_WIDTH-1:0]         A3,
    output logic [DATA_WIDTH-1:0]                WD3,

    output logic                                 any_pending
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW    = ADDRESS_BIT_WIDTH;
    localparam int DW    = DATA_WIDTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]       ptr_q,  ptr_d;   // last granted requester
    logic [NB_OF_REGS-1:0]  sb_q,   sb_d;    // pending-write scoreboard
    logic                   we3_q,  we3_d;
    logic [AW-1:0]          a3_q,   a3_d;
    logic [DW-1:0]          wd3_q,  wd3_d;

    // ------------------------------------------------------------------
    // Arbitration results
    // ------------------------------------------------------------------
    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic [N_REQ-1:0]       grant_oh;
    logic [AW-1:0]          grant_addr;
    logic [DW-1:0]          grant_data;

    // Round-robin arbiter: first valid requester scanning upward from ptr+1.
    // Reset also blocks the grant so nothing is handshaken while the block
    // is being cleared.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every signal driven here gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = 0;
        cand_idx  = '0;
        if (en && !rst) begin
            for (int i = 1; i <= N_REQ; i++) begin
                cand     = (int'(ptr_q) + i) % N_REQ;
                cand_idx = IDX_W'(cand);
                if (!grant_vld && req_valid[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Select the granted requester's address and data from the packed buses.
    always_comb begin
        grant_addr = '0;
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_oh[k]) begin
                grant_addr = req_addr[k*AW +: AW];
                grant_data = req_data[k*DW +: DW];
            end
        end
    end

    // Scoreboard update: grant clears, issue sets; set is applied last so a
    // new producer outstanding on the same register wins. x0 never pends.
    always_comb begin
        sb_d = sb_q;
        if (en) begin
            if (grant_vld) begin
                sb_d[grant_addr] = 1'b0;
            end
            if (issue_valid && (issue_rd != '0)) begin
                sb_d[issue_rd] = 1'b1;
            end
        end
        sb_d[0] = 1'b0;
    end

    // Write-port and pointer next state: a grant loads A3/WD3 and moves the
    // pointer; WE3 pulses only for non-zero destinations. Without a grant
    // A3/WD3 hold their last value and WE3 drops.
    always_comb begin
        ptr_d = ptr_q;
        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (grant_vld) begin
            ptr_d = grant_idx;
            a3_d  = grant_addr;
            wd3_d = grant_data;
            we3_d = (grant_addr != '0);
        end
    end

    // State registers; pointer resets to N_REQ-1 so requester 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            ptr_q <= IDX_W'(N_REQ - 1);
            sb_q  <= '0;
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            sb_q  <= sb_d;
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = grant_oh;
    assign WE3         = we3_q;
    assign A3          = a3_q;
    assign WD3         = wd3_q;
    assign rs1_busy    = sb_q[rs1_addr];
    assign rs2_busy    = sb_q[rs2_addr];
    assign any_pending = |sb_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// Directed bench for regfile_wb_scheduler. Inputs change 1 ns after each
// rising edge; combinational outputs are checked 1 ns after that, registered
// outputs 1 ns after the edge that loads them.
// ----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int NQ = 3;

    logic              clk;
    logic              rst;
    logic              en;
    logic [NQ-1:0]     req_valid;
    logic [NQ*AW-1:0]  req_addr;
    logic [NQ*DW-1:0]  req_data;
    logic [NQ-1:0]     req_ready;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic [AW-1:0]     rs1_addr;
    logic [AW-1:0]     rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              WE3;
    logic [AW-1:0]     A3;
    logic [DW-1:0]     WD3;
    logic              any_pending;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_scheduler #(
        .DATA_WIDTH(DW), .NB_OF_REGS(NR), .ADDRESS_BIT_WIDTH(AW), .N_REQ(NQ)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .WE3(WE3), .A3(A3), .WD3(WD3), .any_pending(any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [NQ-1:0] exp_rdy;

        rst = 1'b1; en = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;

        // ---- 1: reset state and single ALU writeback
        step(); step();
        check("rst_we3", 64'(WE3), 64'd0);
        check("rst_a3", 64'(A3), 64'd0);
        check("rst_wd3", 64'(WD3), 64'd0);
        check("rst_pending", 64'(any_pending), 64'd0);
        rst = 1'b0;
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'h0000_2004);
        #1;
        check("t1_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        check("t1_we3", 64'(WE3), 64'd1);
        check("t1_a3", 64'(A3), 64'd5);
        check("t1_wd3", 64'(WD3), 64'h2004);
        step();
        check("t1_we3_drop", 64'(WE3), 64'd0);

        // ---- 2: fairness with all three requesters valid (fresh pointer)
        do_reset();
        req_valid = 3'b111;
        for (int k = 0; k < NQ; k++) set_req(k, AW'(k + 1), 32'h100 + 32'(k));
        for (int c = 0; c < 6; c++) begin
            exp_rdy = NQ'(1 << (c % 3));
            #1;
            check($sformatf("t2_ready_%0d", c), 64'(req_ready), 64'(exp_rdy));
            step();
            check($sformatf("t2_we3_%0d", c), 64'(WE3), 64'd1);
            check($sformatf("t2_a3_%0d", c), 64'(A3), 64'((c % 3) + 1));
            check($sformatf("t2_wd3_%0d", c), 64'(WD3), 64'(32'h100 + 32'(c % 3)));
        end
        req_valid = '0;

        // ---- 3: issue rd=9, then LSU writeback clears it
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        rs1_addr = 5'd9;
        #1;
        check("t3_busy_set", 64'(rs1_busy), 64'd1);
        check("t3_pending", 64'(any_pending), 64'd1);
        req_valid = 3'b010;
        set_req(1, 5'd9, 32'h0000_0099);
        #1;
        check("t3_ready", 64'(req_ready), 64'b010);
        step();
        req_valid = '0;
        check("t3_busy_clr", 64'(rs1_busy), 64'd0);
        check("t3_pending_clr", 64'(any_pending), 64'd0);
        check("t3_a3", 64'(A3), 64'd9);

        // ---- 4: set and clear of bit 7 in the same cycle, set wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        rs2_addr = 5'd7;
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h0000_0077);
        #1;
        check("t4_ready", 64'(req_ready), 64'b001);
        step();
        issue_valid = 1'b0;
        req_valid = '0;
        check("t4_set_wins", 64'(rs2_busy), 64'd1);
        check("t4_we3", 64'(WE3), 64'd1);
        req_valid = 3'b100;
        set_req(2, 5'd7, 32'h0000_0707);
        #1;
        check("t4_ready2", 64'(req_ready), 64'b100);
        step();
        req_valid = '0;
        check("t4_cleared", 64'(rs2_busy), 64'd0);

        // ---- 5: writeback to x0 is consumed but suppressed
        req_valid = 3'b001;
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("t5_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        check("t5_we3", 64'(WE3), 64'd0);
        check("t5_a3", 64'(A3), 64'd0);
        check("t5_wd3", 64'(WD3), 64'hFFFF_FFFF);
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        issue_valid = 1'b0;
        rs1_addr = 5'd0;
        #1;
        check("t5_x0_busy", 64'(rs1_busy), 64'd0);
        check("t5_x0_pending", 64'(any_pending), 64'd0);

        // ---- 6a: en=0 freezes grants and the scoreboard
        en = 1'b0;
        req_valid = 3'b010;
        set_req(1, 5'd4, 32'h0000_0044);
        issue_valid = 1'b1; issue_rd = 5'd12;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("t6_ready_off_%0d", c), 64'(req_ready), 64'd0);
            step();
            check($sformatf("t6_we3_off_%0d", c), 64'(WE3), 64'd0);
        end
        issue_valid = 1'b0;
        rs1_addr = 5'd12;
        #1;
        check("t6_no_issue", 64'(rs1_busy), 64'd0);
        en = 1'b1;
        #1;
        check("t6_ready_on", 64'(req_ready), 64'b010);
        step();
        req_valid = '0;
        check("t6_we3_on", 64'(WE3), 64'd1);
        check("t6_a3_on", 64'(A3), 64'd4);

        // ---- 6b: async reset while WE3 is high
        issue_valid = 1'b1; issue_rd = 5'd15;
        req_valid = 3'b100;
        set_req(2, 5'd6, 32'h0000_0666);
        step();
        issue_valid = 1'b0;
        rs1_addr = 5'd15;
        #1;
        check("t6_pre_we3", 64'(WE3), 64'd1);
        check("t6_pre_busy", 64'(rs1_busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_we3", 64'(WE3), 64'd0);
        check("t6_rst_a3", 64'(A3), 64'd0);
        check("t6_rst_wd3", 64'(WD3), 64'd0);
        check("t6_rst_busy", 64'(rs1_busy), 64'd0);
        check("t6_rst_ready", 64'(req_ready), 64'd0);
        step();
        req_valid = '0;
        rst = 1'b0;
        step();
        check("t6_after_rst_we3", 64'(WE3), 64'd0);
        check("t6_after_rst_pending", 64'(any_pending), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences all writes into the single register-file write port (A3/WD3/WE3) and arbitrates round-robin between N_REQ writeback requesters (ALU, load unit, CSR unit).
- Keeps a per-register pending-write scoreboard, set by decode at issue and cleared at writeback. Decode uses it for RAW hazard checks on rs1/rs2.
- Sits between the execute/memory stages and the register file.

Parameters:
DATA_WIDTH, 32, register data width
NB_OF_REGS, 32, number of architectural registers
ADDRESS_BIT_WIDTH, 5, register index width
N_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = CSR)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
en  input  1  global enable; low freezes the block
req_valid  input  N_REQ  per-requester writeback valid
req_addr  input  N_REQ*ADDRESS_BIT_WIDTH  packed destination index; requester k at slice k
req_data  input  N_REQ*DATA_WIDTH  packed writeback data; requester k at slice k
req_ready  output  N_REQ  one-hot grant (combinational)
issue_valid  input  1  decode issues an instruction that writes issue_rd
issue_rd  input  ADDRESS_BIT_WIDTH  destination of the issued instruction
rs1_addr  input  ADDRESS_BIT_WIDTH  hazard query 1
rs2_addr  input  ADDRESS_BIT_WIDTH  hazard query 2
rs1_busy  output  1  scoreboard[rs1_addr] (combinational from state)
rs2_busy  output  1  scoreboard[rs2_addr]
WE3  output  1  registered write enable to register file
A3  output  ADDRESS_BIT_WIDTH  registered write index
WD3  output  DATA_WIDTH  registered write data
any_pending  output  1  OR of all scoreboard bits

Behaviour:
- Reset (async, rst=1):
  - WE3=0, A3=0, WD3=0.
  - Scoreboard all 0; rs1_busy, rs2_busy and any_pending therefore 0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - Reset asserted mid-transfer discards any in-flight grant; the next cycle after release starts clean.
- Arbitration (combinational):
  - When en=1 and any req_valid is set, grant exactly one requester: the first valid index scanning upward (modulo N_REQ) from pointer+1.
  - req_ready is that one-hot grant. All zeros when en=0 or no request is valid.
  - Handshake completes when req_valid[k] and req_ready[k] are both high. Requesters hold valid/addr/data stable until granted. Ungranted requesters wait with no loss.
- Grant effects (registered, posedge):
  - Pointer ← granted index.
  - A3 ← granted addr; WD3 ← granted data.
  - WE3 ← 1 if the granted addr ≠ 0, else 0. A write to x0 is consumed but suppressed.
  - Latency: one cycle from handshake to the WE3 pulse.
  - With no grant: WE3 ← 0; A3 and WD3 hold.
- Scoreboard:
  - On posedge with en=1, a grant clears bit[granted addr].
  - issue_valid with issue_rd ≠ 0 sets bit[issue_rd]. issue_rd = 0 never sets a bit; bit 0 is constant 0.
  - If set and clear hit the same index in the same cycle, set wins (a new producer is outstanding).
  - A clear for a bit that is already 0 is legal and has no effect.
- en=0: no grants, WE3 ← 0, scoreboard and pointer hold, busy outputs still reflect state.
- Timing with the register file:
  - The register file commits on the negedge after WE3 rises.
  - The busy bit drops at that same posedge. A consumer reading after that negedge sees the new value; no bypass is provided.
- Fairness: with all N_REQ requesters continuously valid, each is granted once every N_REQ cycles.

Test Plan:
1. Reset with rst=1, then release. Drive req_valid=3'b001, addr=5, data=0x2004 → req_ready=3'b001 the same cycle. Next cycle WE3=1, A3=5, WD3=0x2004. Following cycle WE3=0.
2. Hold req_valid=3'b111 with addrs 1/2/3 for 6 cycles → grants 0,1,2,0,1,2. WE3 stays high each following cycle with A3=1,2,3,1,2,3.
3. Issue rd=9, then query rs1_addr=9 → rs1_busy=1 and any_pending=1. LSU writeback to 9 granted → rs1_busy=0 on the next posedge.
4. Same cycle: issue_valid with rd=7 and a writeback grant to addr 7, while bit 7 is already set → bit 7 stays 1.
5. Writeback to addr 0 with data 0xFFFF_FFFF → req_ready=1, WE3=0. Issue rd=0 → rs1_busy for x0 stays 0.
6. req_valid=3'b010 with en=0 for 3 cycles → req_ready=0 and WE3=0. Raise en → granted. Separately, assert rst while WE3=1 → WE3, A3, WD3 and the scoreboard go to 0 immediately, without waiting for a clock edge.
